regfile_wb_arbiter: RTL and testbench

//  Owns the register file's single write port and shares it between the in-order pipeline WB stage
//  and the multi-cycle mul/div unit (MDU). Keeps a busy scoreboard of MDU destinations and raises

---
 rtl/regfile_wb_arbiter_pkg.sv | 22 ++
 rtl/regfile_wb_arbiter_if.sv | 56 +++++
 rtl/regfile_wb_arbiter_rf_scoreboard.sv | 58 +++++
 rtl/regfile_wb_arbiter.sv | 134 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter slice.
// Contents: datapath width, register address width, arbiter FSM state enum,
// and the packed write-port payload (destination + data).
package regfile_wb_arbiter_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  // PIPE: pipeline owns the write port; FORCE: a starved MDU result preempts it
  typedef enum logic [0:0] {
    PIPE  = 1'b0,
    FORCE = 1'b1
  } arb_state_e;

  // One write into the register file
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_payload_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the WB-stage, MDU, decode and register-file write signals around
// regfile_wb_arbiter.
//   master : pipeline/MDU/decode side (drives requests, sees grants and stalls)
//   slave  : the arbiter itself
// Optional macro RF_WB_FWD_EN adds the write-port forwarding signals
// (fwd_rs1_hit, fwd_rs2_hit, fwd_data).
interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;

  logic                  stall_in;
  logic                  pipe_wb_valid;
  logic [REG_ADDR_W-1:0] pipe_rd;
  logic [XLEN-1:0]       pipe_wb_data;
  logic                  mdu_issue;
  logic [REG_ADDR_W-1:0] mdu_issue_rd;
  logic                  mdu_res_valid;
  logic [REG_ADDR_W-1:0] mdu_res_rd;
  logic [XLEN-1:0]       mdu_res_data;
  logic                  mdu_res_ready;
  logic [REG_ADDR_W-1:0] dec_rs1;
  logic [REG_ADDR_W-1:0] dec_rs2;
  logic [REG_ADDR_W-1:0] dec_rd;
  logic                  dec_wr;
  logic                  hazard_stall;
  logic                  wb_stall;
  logic [REG_ADDR_W-1:0] rf_rd;
  logic [XLEN-1:0]       rf_wb;
  logic                  rf_wb_sig;
  logic [NUM_REGS-1:0]   busy;
`ifdef RF_WB_FWD_EN
  logic                  fwd_rs1_hit;
  logic                  fwd_rs2_hit;
  logic [XLEN-1:0]       fwd_data;
`endif

  modport master (
    output stall_in, pipe_wb_valid, pipe_rd, pipe_wb_data,
    output mdu_issue, mdu_issue_rd, mdu_res_valid, mdu_res_rd, mdu_res_data,
    output dec_rs1, dec_rs2, dec_rd, dec_wr,
    input  mdu_res_ready, hazard_stall, wb_stall, rf_rd, rf_wb, rf_wb_sig, busy
`ifdef RF_WB_FWD_EN
    , input fwd_rs1_hit, fwd_rs2_hit, fwd_data
`endif
  );

  modport slave (
    input  stall_in, pipe_wb_valid, pipe_rd, pipe_wb_data,
    input  mdu_issue, mdu_issue_rd, mdu_res_valid, mdu_res_rd, mdu_res_data,
    input  dec_rs1, dec_rs2, dec_rd, dec_wr,
    output mdu_res_ready, hazard_stall, wb_stall, rf_rd, rf_wb, rf_wb_sig, busy
`ifdef RF_WB_FWD_EN
    , output fwd_rs1_hit, fwd_rs2_hit, fwd_data
`endif
  );

endinterface

// File: rtl/regfile_wb_arbiter_rf_scoreboard.sv
// Busy scoreboard of outstanding MDU destinations plus the decode hazard compare.
// Ports:
//   cpu_clk, rst        clock, synchronous active-high reset
//   issue, issue_rd     MDU op issued by decode (accepted only without hazard)
//   clr_en, clr_rd      MDU result written this cycle
//   dec_rs1/rs2/rd/wr   decode operands
//   busy                bit n set while an MDU write to xn is outstanding
//   hazard_stall        RAW/WAW conflict against a busy register
// With RF_WB_FWD_EN, a busy source being written this cycle does not stall.
module rf_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                  cpu_clk,
  input  logic                  rst,
  input  logic                  issue,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  input  logic                  dec_wr,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  hazard_stall
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                src1_busy, src2_busy, dst_busy;

  // Source/destination conflict detection
  always_comb begin
    src1_busy = (dec_rs1 != '0) & busy_q[dec_rs1];
    src2_busy = (dec_rs2 != '0) & busy_q[dec_rs2];
    dst_busy  = dec_wr & (dec_rd != '0) & busy_q[dec_rd];
`ifdef RF_WB_FWD_EN
    // The result landing now is forwarded, so that source is no longer a hazard
    if (clr_en && (clr_rd == dec_rs1)) src1_busy = 1'b0;
    if (clr_en && (clr_rd == dec_rs2)) src2_busy = 1'b0;
`endif
    hazard_stall = ~rst & (src1_busy | src2_busy | dst_busy);
  end

  // Set on accepted issue wins over a same-cycle clear of the same register
  always_comb begin
    busy_d = busy_q;
    if (clr_en)                busy_d[clr_rd]   = 1'b0;
    if (issue & ~hazard_stall) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge cpu_clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy = rst ? '0 : busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between the pipeline WB stage
// and the multi-cycle MDU, and tracks outstanding MDU destinations for decode
// hazard stalls.
// Ports:
//   cpu_clk, rst  clock, synchronous active-high reset
//   bus           regfile_wb_arbiter_if.slave: WB request, MDU result handshake,
//                 decode operands, register-file write port, busy, stalls
// Parameters:
//   MAX_WAIT      refused MDU cycles before the MDU preempts the pipeline (>=1)
//   WAIT_W        wait counter width, must hold MAX_WAIT
// Optional macro RF_WB_FWD_EN: forward the value on the write port to decode.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned WAIT_W   = 3
) (
  input  logic               cpu_clk,
  input  logic               rst,
  regfile_wb_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = WAIT_W + 1;

  arb_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  wait_inc;
  logic              pipe_go;
  logic              pipe_grant, mdu_grant, mdu_refused;
  logic              wb_stall;
  wb_payload_t       win;
  logic              rf_wb_sig;

  assign pipe_go  = bus.pipe_wb_valid & ~bus.stall_in;
  assign wait_inc = CNT_W'(wait_q) + CNT_W'(1);

  // State register
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      state_q <= PIPE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next state: count refusals in PIPE; FORCE lasts a single cycle
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      PIPE: begin
        if (mdu_grant) begin
          wait_d = '0;
        end else if (mdu_refused) begin
          if (wait_q < WAIT_W'(MAX_WAIT)) wait_d = wait_q + WAIT_W'(1);
          if (wait_inc >= CNT_W'(MAX_WAIT)) state_d = FORCE;
        end
      end
      FORCE: begin
        state_d = PIPE;
        wait_d  = '0;
      end
      default: begin
        state_d = PIPE;
        wait_d  = '0;
      end
    endcase
  end

  // Outputs: grant selection and write-port mux
  always_comb begin
    pipe_grant  = 1'b0;
    mdu_grant   = 1'b0;
    mdu_refused = 1'b0;
    wb_stall    = 1'b0;
    win         = '0;
    if (!rst) begin
      case (state_q)
        PIPE: begin
          if (pipe_go)                pipe_grant = 1'b1;
          else if (bus.mdu_res_valid) mdu_grant  = 1'b1;
        end
        FORCE: begin
          // Holding WB keeps the preempted pipe result alive for next cycle
          if (bus.mdu_res_valid) begin
            mdu_grant = 1'b1;
            wb_stall  = 1'b1;
          end
        end
        default: ;
      endcase
      mdu_refused = bus.mdu_res_valid & ~mdu_grant;
    end
    if (pipe_grant) begin
      win.rd   = bus.pipe_rd;
      win.data = bus.pipe_wb_data;
    end else if (mdu_grant) begin
      win.rd   = bus.mdu_res_rd;
      win.data = bus.mdu_res_data;
    end
    // x0 is hardwired: a write to it is accepted but suppressed
    rf_wb_sig = (pipe_grant | mdu_grant) & (win.rd != '0);
  end

  assign bus.rf_rd         = win.rd;
  assign bus.rf_wb         = win.data;
  assign bus.rf_wb_sig     = rf_wb_sig;
  assign bus.mdu_res_ready = mdu_grant;
  assign bus.wb_stall      = wb_stall;

`ifdef RF_WB_FWD_EN
  assign bus.fwd_rs1_hit = rf_wb_sig & (win.rd == bus.dec_rs1) & (bus.dec_rs1 != '0);
  assign bus.fwd_rs2_hit = rf_wb_sig & (win.rd == bus.dec_rs2) & (bus.dec_rs2 != '0);
  assign bus.fwd_data    = win.data;
`endif

  rf_scoreboard u_scoreboard (
    .cpu_clk      (cpu_clk),
    .rst          (rst),
    .issue        (bus.mdu_issue),
    .issue_rd     (bus.mdu_issue_rd),
    .clr_en       (mdu_grant),
    .clr_rd       (bus.mdu_res_rd),
    .dec_rs1      (bus.dec_rs1),
    .dec_rs2      (bus.dec_rs2),
    .dec_rd       (bus.dec_rd),
    .dec_wr       (bus.dec_wr),
    .busy         (bus.busy),
    .hazard_stall (bus.hazard_stall)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// random traffic, each cycle compared against a behavioural model (refusal
// count, busy bit array, priority rules).
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int unsigned MAX_WAIT = 4;
`ifdef RF_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic cpu_clk = 1'b0;
  logic rst;
  always #5 cpu_clk = ~cpu_clk;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT), .WAIT_W(3)) dut (
    .cpu_clk (cpu_clk),
    .rst     (rst),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // stimulus variables
  bit        v_rst, v_stall, v_pv, v_issue, v_dwr;
  bit [4:0]  v_prd, v_ird, v_rs1, v_rs2, v_drd;
  bit [31:0] v_pdata;
  bit        mdu_pend;
  bit [4:0]  mdu_rd;
  bit [31:0] mdu_data;

  // model state
  bit [31:0] m_busy;
  int        m_refused;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit src_hit(input bit [4:0] rs, input bit mw);
    return (rs != 0) && m_busy[rs] && !(FWD && mw && (mdu_rd == rs));
  endfunction

  task automatic idle();
    v_rst = 0; v_stall = 0; v_pv = 0; v_issue = 0; v_dwr = 0;
    v_prd = 0; v_ird = 0; v_rs1 = 0; v_rs2 = 0; v_drd = 0; v_pdata = 0;
  endtask

  // Apply one cycle of inputs, compare all outputs with the model, advance the model
  task automatic step();
    bit go, prio, pw, mw, hz, sig, exp_ws;
    bit [4:0]  wrd;
    bit [31:0] wdat, nb;
    @(negedge cpu_clk);
    rst               = v_rst;
    bus.stall_in      = v_stall;
    bus.pipe_wb_valid = v_pv;
    bus.pipe_rd       = v_prd;
    bus.pipe_wb_data  = v_pdata;
    bus.mdu_issue     = v_issue;
    bus.mdu_issue_rd  = v_ird;
    bus.mdu_res_valid = mdu_pend;
    bus.mdu_res_rd    = mdu_rd;
    bus.mdu_res_data  = mdu_data;
    bus.dec_rs1       = v_rs1;
    bus.dec_rs2       = v_rs2;
    bus.dec_rd        = v_drd;
    bus.dec_wr        = v_dwr;
    #1;
    if (v_rst) begin
      chk_eq("rst_sig",    32'(bus.rf_wb_sig), 0);
      chk_eq("rst_rd",     32'(bus.rf_rd), 0);
      chk_eq("rst_wb",     bus.rf_wb, 0);
      chk_eq("rst_ready",  32'(bus.mdu_res_ready), 0);
      chk_eq("rst_wbst",   32'(bus.wb_stall), 0);
      chk_eq("rst_hazard", 32'(bus.hazard_stall), 0);
      chk_eq("rst_busy",   bus.busy, 0);
`ifdef RF_WB_FWD_EN
      chk_eq("rst_fwd", {30'd0, bus.fwd_rs1_hit, bus.fwd_rs2_hit}, 0);
`endif
      m_busy = 0; m_refused = 0; mdu_pend = 0;
    end else begin
      go   = v_pv && !v_stall;
      prio = (m_refused >= MAX_WAIT);
      if (prio) begin pw = 0; mw = mdu_pend; end
      else      begin pw = go; mw = !go && mdu_pend; end
      exp_ws = prio && mdu_pend;
      wrd  = pw ? v_prd : (mw ? mdu_rd : 5'd0);
      wdat = pw ? v_pdata : mdu_data;
      sig  = (pw || mw) && (wrd != 0);
      hz   = src_hit(v_rs1, mw) || src_hit(v_rs2, mw) ||
             (v_dwr && v_drd != 0 && m_busy[v_drd]);
      chk_eq("ready",    32'(bus.mdu_res_ready), 32'(mw));
      chk_eq("wb_stall", 32'(bus.wb_stall), 32'(exp_ws));
      chk_eq("rf_sig",   32'(bus.rf_wb_sig), 32'(sig));
      chk_eq("hazard",   32'(bus.hazard_stall), 32'(hz));
      chk_eq("busy",     bus.busy, m_busy);
      if (sig) begin
        chk_eq("rf_rd", 32'(bus.rf_rd), 32'(wrd));
        chk_eq("rf_wb", bus.rf_wb, wdat);
      end
`ifdef RF_WB_FWD_EN
      chk_eq("fwd1", 32'(bus.fwd_rs1_hit), 32'(sig && wrd == v_rs1 && v_rs1 != 0));
      chk_eq("fwd2", 32'(bus.fwd_rs2_hit), 32'(sig && wrd == v_rs2 && v_rs2 != 0));
      if (sig) chk_eq("fwd_data", bus.fwd_data, wdat);
`endif
      nb = m_busy;
      if (mw) nb[mdu_rd] = 1'b0;
      if (v_issue && !hz) nb[v_ird] = 1'b1;
      nb[0] = 1'b0;
      m_busy = nb;
      if (prio || mw) m_refused = 0;
      else if (mdu_pend && m_refused < MAX_WAIT) m_refused++;
      if (mw) mdu_pend = 0;
    end
  endtask

  initial begin
    idle();
    mdu_pend = 0; mdu_rd = 0; mdu_data = 0;
    m_busy = 0; m_refused = 0;

    // reset with live requests: everything must read zero
    v_rst = 1; v_pv = 1; v_prd = 5; v_pdata = 32'hDEAD;
    mdu_pend = 1; mdu_rd = 4; mdu_data = 32'h55;
    step(); mdu_pend = 1; step();
    idle(); mdu_pend = 0;

    // 1: pipe write lands the same cycle
    v_pv = 1; v_prd = 5; v_pdata = 32'h1234;
    step();
    chk_eq("t1_sig", 32'(bus.rf_wb_sig), 1);
    chk_eq("t1_rd",  32'(bus.rf_rd), 5);
    chk_eq("t1_wb",  bus.rf_wb, 32'h1234);
    idle();

    // 2: issue x7, RAW on x7, result clears busy
    v_issue = 1; v_ird = 7; step(); idle();
    v_rs1 = 7; step();
    chk_eq("t2_hazard", 32'(bus.hazard_stall), 1);
    chk_eq("t2_busy7",  32'(bus.busy[7]), 1);
    idle();
    mdu_pend = 1; mdu_rd = 7; mdu_data = 32'h77; step();
    step();
    chk_eq("t2_busy7_clr", 32'(bus.busy[7]), 0);

    // 3: pipe writes every cycle, MDU x9 preempts on the fifth
    mdu_pend = 1; mdu_rd = 9; mdu_data = $urandom;
    for (int i = 0; i < 5; i++) begin
      v_pv = 1; v_prd = 5'(i + 1); v_pdata = $urandom;
      step();
      chk_eq("t3_ready", 32'(bus.mdu_res_ready), 32'(i == 4));
      if (i == 4) chk_eq("t3_wbstall", 32'(bus.wb_stall), 1);
    end
    idle();

    // 4: external stall lets MDU in
    v_stall = 1; v_pv = 1; v_prd = 6; v_pdata = 32'h66;
    mdu_pend = 1; mdu_rd = 2; mdu_data = 32'h22;
    step();
    chk_eq("t4_ready", 32'(bus.mdu_res_ready), 1);
    chk_eq("t4_rd",    32'(bus.rf_rd), 2);
    idle();

    // 5: MDU write to x0 is accepted but suppressed
    mdu_pend = 1; mdu_rd = 0; mdu_data = 32'hFFFF_FFFF;
    step();
    chk_eq("t5_ready", 32'(bus.mdu_res_ready), 1);
    chk_eq("t5_sig",   32'(bus.rf_wb_sig), 0);

    // 6: result for busy x3 while decode reads x3
    v_issue = 1; v_ird = 3; step(); idle();
    mdu_pend = 1; mdu_rd = 3; mdu_data = 32'hAB; v_rs2 = 3;
    step();
`ifdef RF_WB_FWD_EN
    chk_eq("t6_fwd2",   32'(bus.fwd_rs2_hit), 1);
    chk_eq("t6_fdata",  bus.fwd_data, 32'hAB);
    chk_eq("t6_hazard", 32'(bus.hazard_stall), 0);
`else
    chk_eq("t6_hazard", 32'(bus.hazard_stall), 1);
`endif
    idle();

    // random traffic with occasional mid-operation reset
    for (int c = 0; c < 3000; c++) begin
      v_rst   = ($urandom_range(0, 199) == 0);
      v_stall = ($urandom_range(0, 3) == 0);
      v_pv    = ($urandom_range(0, 9) < 7);
      v_prd   = 5'($urandom_range(0, 7));
      v_pdata = $urandom;
      v_issue = ($urandom_range(0, 2) == 0);
      v_ird   = 5'($urandom_range(0, 7));
      v_rs1   = 5'($urandom_range(0, 7));
      v_rs2   = 5'($urandom_range(0, 7));
      v_drd   = 5'($urandom_range(0, 7));
      v_dwr   = ($urandom_range(0, 1) == 1);
      if (!mdu_pend && $urandom_range(0, 2) == 0) begin
        mdu_pend = 1;
        mdu_rd   = 5'($urandom_range(0, 7));
        mdu_data = $urandom;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
